// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - operand/result bundle for the bit-serial add/subtract sequencer
// Signals:
//   start, sub, a, b        request side, driven by the master
//   busy, done, sum,
//   cout, overflow          status/result side, driven by the sequencer (slave)
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract sequencer around a single full-adder cell
// adder_one ports:
//   a_i, b_i, c_i   operand bits and carry in
//   s_o, c_o        sum bit and carry out
// serial_adder_ctrl ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   bus             serial_adder_ctrl_if.slave (start/sub/a/b in, busy/done/sum/cout/overflow out)
module adder_one (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] acc_d;

    adder_one u_cell (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (bit_s),
        .c_o (bit_c)
    );

    // Sum bits enter at the MSB so after WIDTH shifts the LSB-first stream lands in place.
    assign acc_d = {bit_s, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= bit_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_q   <= acc_d;
                        cout_q  <= bit_c;
                        // carry_q is the carry into the MSB on this edge.
                        ovf_q   <= carry_q ^ bit_c;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract sequencer built around one instance of the team's one-bit full-adder cell (`adder_one`). It accepts two WIDTH-bit operands on a start strobe and streams them LSB-first through the single cell, one bit per clock, holding the carry in a register between bits. It then presents the registered sum, carry-out and signed overflow with a one-cycle done pulse. It serves area-constrained datapaths that trade latency for a single adder cell.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (a − b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result outputs valid from this cycle.
- sum  output  WIDTH  result; holds the last value until the next done.
- cout  output  1  carry-out; for subtract, 1 = no borrow (a ≥ b unsigned).
- overflow  output  1  two's-complement overflow of the last result.

## Operation

- State machine: IDLE, RUN.
- IDLE: on the edge where start=1:
  - load A shift register with a.
  - load B shift register with b, or ~b when sub=1.
  - carry register ← sub.
  - bit counter ← 0.
  - go to RUN.
  - start=0 keeps the block in IDLE.
- RUN, each edge:
  - The full-adder cell combines A[0], B[0] and the carry register.
  - The sum bit shifts into the MSB of the sum shift register (right shift).
  - A and B shift right by one.
  - carry register ← cell carry-out.
  - counter increments.
- Final bit (counter = WIDTH−1):
  - Capture the carry into the MSB (the current carry register) for overflow.
  - sum ← completed sum shift register (including the final bit).
  - cout ← cell carry-out.
  - overflow ← carry-into-MSB XOR carry-out.
  - done ← 1.
  - Return to IDLE.
- start, a, b and sub are ignored while in RUN; no queueing.
- done is 0 in every cycle except the cycle after the final-bit edge.
- busy = 1 exactly when state = RUN.
- Arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1.

## Timing

- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, overflow 0, internal shift/carry/counter registers 0.
- Reset mid-operation: immediate abort to the reset values. The partial result is discarded and done is not pulsed.
- Latency: start sampled at edge E0. Bits are processed at edges E1..E_WIDTH. done is high in the cycle following E_WIDTH.
- busy rises after E0 and falls after E_WIDTH, in the same cycle done rises.
- Back-to-back operation: start held high during the done cycle is accepted at the next edge. Minimum issue period is WIDTH+1 cycles.
- sum, cout and overflow change only at the final-bit edge or on reset. They are stable between done pulses.
- start held continuously high issues a new operation every WIDTH+1 cycles.

## Test plan

- Add, no carry: WIDTH=8, a=0x35, b=0x4A, sub=0, start pulse.
  - Expect done exactly 8 cycles after the start edge.
  - Expect sum=0x7F, cout=0, overflow=0.
  - Expect busy high for exactly 8 cycles.
- Carry / signed overflow:
  - 0xFF+0x01 → sum=0x00, cout=1, overflow=0.
  - 0x7F+0x01 → sum=0x80, cout=0, overflow=1.
- Subtract:
  - 0x10−0x20 → sum=0xF0, cout=0, overflow=0.
  - 0x80−0x01 → sum=0x7F, cout=1, overflow=1.
  - 0x05−0x05 → sum=0x00, cout=1.
- Busy protection and back-to-back:
  - Pulse start with new operands at RUN cycle 3; the pulse must be ignored and the first result is unchanged.
  - Then hold start during done with 0x01+0x02. Expect a second done 9 cycles after the first, with sum=0x03.
- Reset mid-operation: assert rst asynchronously (between edges) at RUN cycle 4.
  - Expect busy, done, sum, cout and overflow at 0 immediately.
  - After release, 0x12+0x34 yields sum=0x46 with normal 8-cycle latency.
- Parameter sweep: WIDTH=2 and WIDTH=16, 200 random add/sub operations each against a reference model. Check latency = WIDTH and the exact sum, cout and overflow.
